// File: rtl/pantalla_pkg.sv
// Shared definitions for the pantalla_refresh LCD frame scanner.
//   - state_e        : frame scanner FSM states
//   - CMD_PAGE_BASE  : LCD "set page address" command (OR'd with the page number)
//   - CMD_COL_LO     : LCD "set column address low nibble" command (column 0)
//   - CMD_COL_HI     : LCD "set column address high nibble" command (column 0)
//   - ADDR_RD_W      : screen RAM read address width {page[2:0], col[6:0]}
//   - page_cmd()     : builds the page-select command byte for a page
package pantalla_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_PAGE,
        ST_CMD_CLO,
        ST_CMD_CHI,
        ST_RD,
        ST_LATCH,
        ST_SEND,
        ST_DONE
    } state_e;

    localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
    localparam logic [7:0] CMD_COL_LO    = 8'h00;
    localparam logic [7:0] CMD_COL_HI    = 8'h10;
    localparam int         ADDR_RD_W     = 10;

    function automatic logic [7:0] page_cmd(input logic [2:0] page);
        return CMD_PAGE_BASE | {5'd0, page};
    endfunction

endpackage

// File: rtl/pantalla_refresh_timer.sv
// Idle-time down-counter for automatic frame refresh.
//   clk      in  system clock, rising edge
//   rst      in  asynchronous reset, active-low (counter cleared to 0)
//   load_i   in  load the counter with LOAD_VAL
//   clear_i  in  stop counting (counter to 0); wins over load_i
//   expire_o out high in the last counted cycle; counter is idle (0) afterwards
module pantalla_refresh_timer #(
    parameter int unsigned LOAD_VAL = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = $clog2(LOAD_VAL + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_W'(LOAD_VAL);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count of 1 is the final idle cycle; 0 means the timer is not running.
    assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pantalla_refresh.sv
// Frame scanner for the 128x64 LCD path. On start it walks the screen RAM page
// by page and streams, per page, the three addressing commands followed by the
// page's pixel bytes to the LCD byte transmitter.
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-low
//   start      in   one-cycle pulse, begins a frame (ignored while busy / in DONE)
//   busy       out  frame in progress
//   frame_done out  one-cycle pulse after the last data byte is accepted
//   addr_rd    out  RAM read address {page[2:0], col[6:0]}
//   rd         out  RAM read strobe, one cycle per byte
//   d_ram      in   RAM read data, captured one cycle after rd
//   tx_byte    out  byte to the transmitter
//   tx_dc      out  0 = command, 1 = display data
//   tx_valid   out  tx_byte/tx_dc valid, held until accepted
//   tx_ready   in   transmitter ready; transfer on tx_valid & tx_ready
// Build option: define PANTALLA_AUTO_REFRESH_EN to self-start a new frame
// REFRESH_CYCLES idle cycles after each frame (adds pantalla_refresh_timer).
module pantalla_refresh
    import pantalla_pkg::*;
#(
    parameter int COLS  = 128,
    parameter int PAGES = 8
`ifdef PANTALLA_AUTO_REFRESH_EN
    ,
    parameter int REFRESH_CYCLES = 50000
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 frame_done,
    output logic [ADDR_RD_W-1:0] addr_rd,
    output logic                 rd,
    input  logic [7:0]           d_ram,
    output logic [7:0]           tx_byte,
    output logic                 tx_dc,
    output logic                 tx_valid,
    input  logic                 tx_ready
);

    state_e                 state_q;
    logic [2:0]             page_q;
    logic [6:0]             col_q;
    logic                   busy_q;
    logic                   frame_done_q;
    logic [ADDR_RD_W-1:0]   addr_rd_q;
    logic                   rd_q;
    logic [7:0]             tx_byte_q;
    logic                   tx_dc_q;
    logic                   tx_valid_q;

    logic [2:0]             page_d;
    logic [6:0]             col_d;
    logic                   col_last;
    logic                   page_last;
    logic                   start_go;

    // Wrap points are explicit compares so COLS/PAGES below the counter range work.
    assign col_last  = (col_q  == 7'(COLS - 1));
    assign page_last = (page_q == 3'(PAGES - 1));
    assign col_d     = col_q + 7'd1;
    assign page_d    = page_q + 3'd1;

`ifdef PANTALLA_AUTO_REFRESH_EN
    logic tmr_expire;

    // Loaded on the DONE cycle; an external start accepted in IDLE cancels the count.
    pantalla_refresh_timer #(
        .LOAD_VAL (REFRESH_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (state_q == ST_DONE),
        .clear_i  (start && (state_q == ST_IDLE)),
        .expire_o (tmr_expire)
    );

    assign start_go = start | tmr_expire;
`else
    assign start_go = start;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            page_q       <= '0;
            col_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            addr_rd_q    <= '0;
            rd_q         <= 1'b0;
            tx_byte_q    <= '0;
            tx_dc_q      <= 1'b0;
            tx_valid_q   <= 1'b0;
        end else begin
            rd_q         <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_go) begin
                        page_q     <= '0;
                        col_q      <= '0;
                        busy_q     <= 1'b1;
                        tx_byte_q  <= page_cmd(3'd0);
                        tx_dc_q    <= 1'b0;
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_CMD_PAGE;
                    end
                end
                ST_CMD_PAGE: begin
                    if (tx_ready) begin
                        tx_byte_q <= CMD_COL_LO;
                        state_q   <= ST_CMD_CLO;
                    end
                end
                ST_CMD_CLO: begin
                    if (tx_ready) begin
                        tx_byte_q <= CMD_COL_HI;
                        state_q   <= ST_CMD_CHI;
                    end
                end
                ST_CMD_CHI: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        rd_q       <= 1'b1;
                        addr_rd_q  <= {page_q, col_q};
                        state_q    <= ST_RD;
                    end
                end
                ST_RD: begin
                    // RAM samples the strobe on this edge; data appears next cycle.
                    state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    tx_byte_q  <= d_ram;
                    tx_dc_q    <= 1'b1;
                    tx_valid_q <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        if (col_last) begin
                            col_q <= '0;
                            if (page_last) begin
                                tx_valid_q   <= 1'b0;
                                busy_q       <= 1'b0;
                                frame_done_q <= 1'b1;
                                state_q      <= ST_DONE;
                            end else begin
                                page_q    <= page_d;
                                tx_byte_q <= page_cmd(page_d);
                                tx_dc_q   <= 1'b0;
                                state_q   <= ST_CMD_PAGE;
                            end
                        end else begin
                            col_q      <= col_d;
                            tx_valid_q <= 1'b0;
                            rd_q       <= 1'b1;
                            addr_rd_q  <= {page_q, col_d};
                            state_q    <= ST_RD;
                        end
                    end
                end
                ST_DONE: begin
                    // start is deliberately not looked at here.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign addr_rd    = addr_rd_q;
    assign rd         = rd_q;
    assign tx_byte    = tx_byte_q;
    assign tx_dc      = tx_dc_q;
    assign tx_valid   = tx_valid_q;

endmodule

// File: tb/tb_pantalla_refresh.sv
// Directed testbench for pantalla_refresh: reset state, full frames with and
// without backpressure, ignored start pulses, mid-frame reset and (when
// PANTALLA_AUTO_REFRESH_EN is defined) the automatic refresh interval.
module tb_pantalla_refresh;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       frame_done;
    logic [9:0] addr_rd;
    logic       rd;
    logic [7:0] d_ram;
    logic [7:0] tx_byte;
    logic       tx_dc;
    logic       tx_valid;
    logic       tx_ready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 2;   // 0: always ready, 1: ready 30% of cycles, 2: coin flip
    int fd_cnt   = 0;
    int rd_cnt   = 0;

    logic [7:0] mem [1024];
    logic [7:0] ram_q = 8'h00;
    logic [8:0] xq[$];  // accepted transfers {dc, byte}
    logic       prev_stall = 1'b0;
    logic [8:0] prev_word  = 9'h000;

    always #5 clk = ~clk;

`ifdef PANTALLA_AUTO_REFRESH_EN
    pantalla_refresh #(.REFRESH_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
        .addr_rd(addr_rd), .rd(rd), .d_ram(d_ram), .tx_byte(tx_byte), .tx_dc(tx_dc),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );
`else
    pantalla_refresh dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
        .addr_rd(addr_rd), .rd(rd), .d_ram(d_ram), .tx_byte(tx_byte), .tx_dc(tx_dc),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );
`endif

    // Synchronous screen RAM: one cycle read latency.
    always @(posedge clk) if (rd) ram_q <= mem[addr_rd];
    assign d_ram = ram_q;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ($urandom_range(0, 99) < 30);
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Transfer recorder and hold-under-backpressure check.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_word", 32'({tx_dc, tx_byte}), 32'(prev_word));
            end
            if (tx_valid && tx_ready) xq.push_back({tx_dc, tx_byte});
            if (frame_done) fd_cnt++;
            if (rd) rd_cnt++;
            prev_stall = tx_valid && !tx_ready;
            prev_word  = {tx_dc, tx_byte};
        end
    end

    task automatic clear_log();
        xq.delete();
        fd_cnt = 0;
        rd_cnt = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit, input string nm);
        int n = 0;
        while (fd_cnt < target && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        chk({nm, "_done_in_time"}, 32'(fd_cnt >= target), 32'd1);
    endtask

    task automatic check_frame(input string nm);
        int i = 0;
        logic [9:0] a;
        logic [8:0] e;
        chk({nm, "_len"}, 32'(xq.size()), 32'd1048);
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < 131; k++) begin
                if (k == 0)      e = {1'b0, 8'hB0 | 8'(p)};
                else if (k == 1) e = 9'h000;
                else if (k == 2) e = 9'h010;
                else begin
                    a = {3'(p), 7'(k - 3)};
                    e = {1'b1, a[7:0] ^ 8'h5A};
                end
                if (i < xq.size()) chk($sformatf("%s_p%0d_k%0d", nm, p, k), 32'(xq[i]), 32'(e));
                i++;
            end
        end
    endtask

    initial begin
        int vcnt;
        int n;
        int gap;

        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;

        // Reset held with random inputs.
        rdy_mode = 2;
        repeat (20) begin
            @(posedge clk); #1 start = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_addr_rd", 32'(addr_rd), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'd0);
        chk("rst_tx_dc", 32'(tx_dc), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);

        // Released, no start: stays silent.
        @(posedge clk); #1 start = 1'b0; rst = 1'b1; rdy_mode = 0;
        vcnt = 0;
        repeat (1000) begin
            @(negedge clk); #1;
            if (tx_valid || busy) vcnt++;
        end
        chk("idle_quiet", 32'(vcnt), 32'd0);

        // Full frame, always ready.
        clear_log();
        pulse_start();
        chk("first_busy", 32'(busy), 32'd1);
        chk("first_valid", 32'(tx_valid), 32'd1);
        chk("first_word", 32'({tx_dc, tx_byte}), 32'h0B0);
        wait_done(1, 20000, "full");
        repeat (3) @(negedge clk);
        #1;
        chk("full_busy_off", 32'(busy), 32'd0);
        chk("full_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("full_rd_cnt", 32'(rd_cnt), 32'd1024);
        check_frame("full");

        // Backpressure.
        do_reset();
        clear_log();
        rdy_mode = 1;
        pulse_start();
        wait_done(1, 40000, "bp");
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("bp_busy_off", 32'(busy), 32'd0);
        chk("bp_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("bp_rd_cnt", 32'(rd_cnt), 32'd1024);
        check_frame("bp");

        // Start pulses while busy and in the DONE cycle are ignored.
        do_reset();
        clear_log();
        pulse_start();
        n = 0;
        while (xq.size() < 2 * 131 + 20 && n < 20000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("ign_reach_page2", 32'(xq.size() >= 2 * 131 + 20), 32'd1);
        pulse_start();
        repeat (7) @(posedge clk);
        pulse_start();
        n = 0;
        while (!frame_done && n < 20000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("ign_saw_done", 32'(frame_done), 32'd1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("ign_busy_off", 32'(busy), 32'd0);
        chk("ign_valid_off", 32'(tx_valid), 32'd0);
        chk("ign_fd_cnt", 32'(fd_cnt), 32'd1);
`ifndef PANTALLA_AUTO_REFRESH_EN
        repeat (1000) @(negedge clk);
        #1;
        chk("ign_no_restart", 32'(busy), 32'd0);
        chk("ign_fd_cnt_late", 32'(fd_cnt), 32'd1);
`endif
        check_frame("ign");

        // Reset in the middle of page 3, column 40.
        do_reset();
        clear_log();
        pulse_start();
        n = 0;
        while (xq.size() < 3 * 131 + 3 + 40 && n < 20000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("mid_reach_p3c40", 32'(xq.size() >= 3 * 131 + 3 + 40), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_valid", 32'(tx_valid), 32'd0);
        chk("mid_rd", 32'(rd), 32'd0);
        chk("mid_addr", 32'(addr_rd), 32'd0);
        chk("mid_word", 32'({tx_dc, tx_byte}), 32'd0);
        chk("mid_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        clear_log();
        pulse_start();
        chk("restart_word", 32'({tx_dc, tx_byte}), 32'h0B0);
        wait_done(1, 20000, "restart");
        check_frame("restart");

`ifdef PANTALLA_AUTO_REFRESH_EN
        // Self-start after the idle interval.
        do_reset();
        clear_log();
        pulse_start();
        wait_done(1, 20000, "auto1");
        gap = 0;
        while (!tx_valid && gap < 100) begin
            @(negedge clk); #1;
            gap++;
        end
        chk("auto_gap", 32'(gap >= 16 && gap <= 18), 32'd1);
        wait_done(2, 20000, "auto2");
        // External start during the count takes effect at once.
        repeat (5) @(negedge clk);
        pulse_start();
        chk("auto_ext_valid", 32'(tx_valid), 32'd1);
        chk("auto_ext_word", 32'({tx_dc, tx_byte}), 32'h0B0);
        wait_done(3, 20000, "auto3");
        gap = 0;
        while (!tx_valid && gap < 100) begin
            @(negedge clk); #1;
            gap++;
        end
        chk("auto_gap2", 32'(gap >= 16 && gap <= 18), 32'd1);
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
